loopback_prbs_checker: RTL and testbench

LOOPBACK_PRBS_CHECKER -- requirements
Module: loopback_prbs_checker

---
 rtl/loopback_pkg.sv | 21 ++
 rtl/prbs7_adv.sv | 28 ++
 rtl/loopback_prbs_checker.sv | 137 +++++++++++++
 tb/tb_loopback_prbs_checker.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/loopback_pkg.sv
// Shared types and constants for the PRBS-7 loopback generator/checker.
// The popcount helper sizes error increments for any bus width up to 64 bits.
package loopback_pkg;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_e;

    // x^7 + x^6 + 1: feedback is state[6] ^ state[5]
    localparam logic [6:0] PRBS7_TAPS = 7'h60;
    localparam logic [6:0] PRBS7_SEED = 7'h7F;

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) n += 32'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/prbs7_adv.sv
// Combinational N-step PRBS-7 advance; word[0] is the first (oldest) bit produced.
// state[0] holds the newest bit, so a received-bit history can be fed in directly.
module prbs7_adv
    import loopback_pkg::*;
#(
    parameter int N = 5
) (
    input  logic [6:0]   state,
    output logic [6:0]   next_state,
    output logic [N-1:0] word
);

    logic [6:0] s;
    logic       b;

    always_comb begin
        s    = state;
        b    = 1'b0;
        word = '0;
        for (int i = 0; i < N; i++) begin
            b       = ^(s & PRBS7_TAPS);
            word[i] = b;
            s       = {s[5:0], b};
        end
        next_state = s;
    end

endmodule

// File: rtl/loopback_prbs_checker.sv
// PRBS-7 loopback generator and self-synchronising checker with lock tracking
// and a saturating bit-error counter.
module loopback_prbs_checker
    import loopback_pkg::*;
#(
    parameter int DATA_WIDTH    = 5,
    parameter int LOCK_COUNT    = 64,
    parameter int LOSS_COUNT    = 4,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     clear,
    output logic [DATA_WIDTH-1:0]    tx_data,
    input  logic [DATA_WIDTH-1:0]    rx_data,
    output logic                     locked,
    output logic                     err_pulse,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(LOSS_COUNT + 1);
    localparam int SW = ERR_CNT_WIDTH + $clog2(DATA_WIDTH + 1) + 1;
    localparam logic [SW-1:0] ERR_MAX = SW'({ERR_CNT_WIDTH{1'b1}});

    logic [6:0]            gen_lfsr, gen_next;
    logic [DATA_WIDTH-1:0] gen_word;

    prbs7_adv #(.N(DATA_WIDTH)) u_gen (
        .state      (gen_lfsr),
        .next_state (gen_next),
        .word       (gen_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_lfsr <= PRBS7_SEED;
            tx_data  <= '0;
        end else if (enable) begin
            gen_lfsr <= gen_next;
            tx_data  <= gen_word;
        end else begin
            tx_data  <= '0;
        end
    end

    chk_state_e            state, state_next;
    logic [DATA_WIDTH-1:0] rx_q, pred, mism;
    logic [6:0]            history, hist_next, chk_lfsr, chk_src, chk_next;
    logic [GW-1:0]         good_cnt;
    logic [BW-1:0]         bad_cnt;
    logic                  word_ok, good_hit, bad_hit, lock_err;
    logic [SW-1:0]         err_sum;

    // Searching predicts from received bits; once locked the checker LFSR free-runs.
    assign chk_src = (state == LOCKED) ? chk_lfsr : history;

    prbs7_adv #(.N(DATA_WIDTH)) u_chk (
        .state      (chk_src),
        .next_state (chk_next),
        .word       (pred)
    );

    always_comb begin
        hist_next = history;
        for (int i = 0; i < DATA_WIDTH; i++) hist_next = {hist_next[5:0], rx_q[i]};
    end

    // An all-zero history predicts all zeros, which would let a dead bus lock.
    assign mism     = pred ^ rx_q;
    assign word_ok  = (mism == '0) && ((state == LOCKED) || (history != '0));
    assign good_hit = (state == SEARCH) && word_ok && (good_cnt == GW'(LOCK_COUNT - 1));
    assign bad_hit  = (state == LOCKED) && !word_ok && (bad_cnt == BW'(LOSS_COUNT - 1));
    assign lock_err = enable && (state == LOCKED) && !word_ok;
    assign err_sum  = SW'(err_count) + SW'(popcount(64'(mism)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SEARCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            SEARCH:  if (enable && good_hit)   state_next = LOCKED;
            LOCKED:  if (!enable || bad_hit)   state_next = SEARCH;
            default:                           state_next = SEARCH;
        endcase
    end

    always_comb begin
        locked = (state == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q     <= '0;
            history  <= '0;
            chk_lfsr <= PRBS7_SEED;
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            rx_q <= rx_data;
            if (!enable) begin
                good_cnt <= '0;
                bad_cnt  <= '0;
            end else begin
                history <= hist_next;
                if (state == LOCKED) begin
                    chk_lfsr <= chk_next;
                    good_cnt <= '0;
                    bad_cnt  <= (word_ok || bad_hit) ? '0 : bad_cnt + 1'b1;
                end else begin
                    bad_cnt  <= '0;
                    good_cnt <= word_ok ? good_cnt + 1'b1 : '0;
                    if (good_hit) chk_lfsr <= hist_next;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= lock_err;
            if (clear)
                err_count <= '0;
            else if (lock_err)
                err_count <= (err_sum > ERR_MAX) ? ERR_CNT_WIDTH'(ERR_MAX)
                                                 : ERR_CNT_WIDTH'(err_sum);
        end
    end

endmodule

// File: tb/tb_loopback_prbs_checker.sv
// Directed bench: external 2-cycle loopback with injectable bit flips, table of
// single-word error injections, plus loss/relock, enable and reset sequences.
module tb_loopback_prbs_checker;

    localparam int DW = 5;
    localparam int LC = 64;
    localparam int EW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          clear = 1'b0;
    logic [DW-1:0] tx_data, rx_data;
    logic          locked, err_pulse;
    logic [EW-1:0] err_count;

    logic [DW-1:0] d1 = '0, d2 = '0, flip = '0;
    logic          force_zero = 1'b0;
    int            total = 0, bad = 0, pulses = 0;
    bit            lock_seen = 1'b0;

    loopback_prbs_checker #(
        .DATA_WIDTH(DW), .LOCK_COUNT(LC), .LOSS_COUNT(4), .ERR_CNT_WIDTH(EW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .tx_data(tx_data), .rx_data(rx_data), .locked(locked),
        .err_pulse(err_pulse), .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        d1 <= tx_data;
        d2 <= d1;
    end
    assign rx_data = force_zero ? '0 : (d2 ^ flip);

    always @(posedge clk) begin
        #1;
        if (err_pulse) pulses++;
        if (locked) lock_seen = 1'b1;
    end

    typedef struct {
        logic [DW-1:0] mask;
        logic          clr;
        logic [EW-1:0] exp_cnt;
        int            exp_pulses;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_lock(input string name, input int budget);
        for (int i = 0; i < budget && !locked; i++) @(negedge clk);
        check(name, 32'(locked), 32'd1);
    endtask

    initial begin
        int p0;
        bit early;
        vecs[0] = '{5'b00100, 1'b0, 4'd1,  1};
        vecs[1] = '{5'b01011, 1'b0, 4'd4,  1};
        vecs[2] = '{5'b00000, 1'b0, 4'd4,  0};
        vecs[3] = '{5'b11111, 1'b0, 4'd9,  1};
        vecs[4] = '{5'b10001, 1'b0, 4'd11, 1};
        vecs[5] = '{5'b11111, 1'b0, 4'd15, 1};
        vecs[6] = '{5'b11111, 1'b0, 4'd15, 1};
        vecs[7] = '{5'b00010, 1'b1, 4'd0,  1};
        vecs[8] = '{5'b00011, 1'b0, 4'd2,  1};

        #2;
        check("rst_tx", 32'(tx_data), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_pulse", 32'(err_pulse), 0);
        check("rst_count", 32'(err_count), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // stuck-at-0 bus
        force_zero = 1'b1;
        enable = 1'b1;
        repeat (500) @(negedge clk);
        check("zero_never_lock", 32'(lock_seen), 0);
        check("zero_count", 32'(err_count), 0);
        enable = 1'b0;
        force_zero = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // exact first words and lock cycle from a fresh seed
        enable = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk);
            if (i == 1)  check("tx_w0", 32'(tx_data), 32'h00);
            if (i == 2)  check("tx_w1", 32'(tx_data), 32'h02);
            if (i == 3)  check("tx_w2", 32'(tx_data), 32'h0C);
            if (i == 4)  check("tx_w3", 32'(tx_data), 32'h08);
            if (i == 69) check("lock_not_early", 32'(locked), 0);
            if (i == 70) check("lock_on_time", 32'(locked), 1);
        end

        p0 = pulses;
        repeat (1000) @(negedge clk);
        check("clean_count", 32'(err_count), 0);
        check("clean_pulses", 32'(pulses - p0), 0);
        check("clean_locked", 32'(locked), 1);

        foreach (vecs[k]) begin
            p0 = pulses;
            flip = vecs[k].mask;
            @(negedge clk);
            flip = '0;
            clear = vecs[k].clr;
            @(negedge clk);
            clear = 1'b0;
            repeat (4) @(negedge clk);
            check($sformatf("vec%0d_count", k), 32'(err_count), 32'(vecs[k].exp_cnt));
            check($sformatf("vec%0d_pulses", k), 32'(pulses - p0), 32'(vecs[k].exp_pulses));
            check($sformatf("vec%0d_locked", k), 32'(locked), 1);
        end

        // four inverted words drop lock on the fourth
        p0 = pulses;
        flip = '1;
        repeat (4) @(negedge clk);
        check("loss_held_3bad", 32'(locked), 1);
        flip = '0;
        @(negedge clk);
        check("loss_on_4th", 32'(locked), 0);
        check("loss_pulses", 32'(pulses - p0), 4);
        check("loss_count_sat", 32'(err_count), 15);
        early = 1'b0;
        repeat (63) begin
            @(negedge clk);
            if (locked) early = 1'b1;
        end
        check("relock_full_count", 32'(early), 0);
        wait_lock("relock", 10);
        check("relock_count_kept", 32'(err_count), 15);

        enable = 1'b0;
        @(negedge clk);
        check("dis_tx", 32'(tx_data), 0);
        check("dis_locked", 32'(locked), 0);
        enable = 1'b1;
        wait_lock("reenable_lock", 80);

        // asynchronous reset mid-lock
        #2 rst_n = 1'b0;
        #1;
        check("arst_tx", 32'(tx_data), 0);
        check("arst_locked", 32'(locked), 0);
        check("arst_pulse", 32'(err_pulse), 0);
        check("arst_count", 32'(err_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        early = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (locked) early = 1'b1;
        end
        check("post_rst_no_early", 32'(early), 0);
        wait_lock("post_rst_lock", 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
